dual_issue_scheduler: RTL and testbench

- Issue scheduler for the dual-issue pipeline. Sits between fetch and the two ID/EX slots.
- Buffers up to two fetched instructions per cycle in a small circular queue.
- Each cycle it issues the head instruction to slot 0. It also issues head+1 to slot 1 when the pair has no intra-pair hazard and no structural conflict.
- A control instruction issues alone and opens a shadow window that blocks wrong-path issue until the branch resolves in decode.

---
 rtl/dual_issue_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_scheduler
// Purpose  : Fetch-side issue queue that feeds two ID/EX slots, pairing the
//            head and head+1 entries when the pair is hazard free. Optional
//            issue statistics are enabled with SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dual_issue_scheduler #(
   parameter int DEPTH      = 4,
   parameter int SHADOW_CYC = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [1:0]               in_valid,
   input  logic [31:0]              in_instr0,
   input  logic [31:0]              in_instr1,
   input  logic [5:0]               in_pc0,
   input  logic [5:0]               in_pc1,
   input  logic [7:0]               in_meta0,
   input  logic [7:0]               in_meta1,
   output logic                     in_ready,
   input  logic                     issue_stall,
   input  logic                     flush,
   output logic                     iss0_valid,
   output logic [31:0]              iss0_instr,
   output logic [5:0]               iss0_pc,
   output logic                     iss1_valid,
   output logic [31:0]              iss1_instr,
   output logic [5:0]               iss1_pc,
   output logic [$clog2(DEPTH):0]   count
`ifdef SCHED_STATS_EN
   ,output logic [15:0]             dual_cnt
   ,output logic [15:0]             single_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = (SHADOW_CYC > 0) ? $clog2(SHADOW_CYC + 1) : 1;

   localparam logic [1:0]    c_CLS_ALU  = 2'b00;
   localparam logic [1:0]    c_CLS_CTRL = 2'b10;
   localparam logic [1:0]    c_CLS_NOP  = 2'b11;
   localparam logic [AW-1:0] c_ONE      = AW'(1);

   typedef enum logic [0:0] {RUN = 1'b0, SHADOW = 1'b1} state_t;

   logic [31:0]   r_instr [DEPTH];
   logic [5:0]    r_pc    [DEPTH];
   logic [7:0]    r_meta  [DEPTH];
   logic [AW-1:0] r_rdPtr, r_wrPtr;
   logic [CW-1:0] r_count;
   logic [SW-1:0] r_shadowCnt;
   state_t        r_state;

   logic [AW-1:0] w_rdPtr1, w_wrPtr1;
   logic [CW-1:0] w_pushCnt, w_popCnt;
   logic          w_push0, w_push1, w_ctrlPop;
   logic [1:0]    w_hCls, w_nCls;
   logic [4:0]    w_hDst, w_nDst, w_nRs, w_nRt;
   logic          w_nUsesRt, w_raw, w_waw;

   assign w_rdPtr1 = r_rdPtr + c_ONE;
   assign w_wrPtr1 = r_wrPtr + c_ONE;

   assign in_ready = (r_count <= CW'(DEPTH - 2));
   assign count    = r_count;

   assign w_push0 = in_ready && in_valid[0] && !flush;
   assign w_push1 = w_push0 && in_valid[1];

   // meta layout: {cls[7:6], dst[5:1], uses_rt[0]}
   assign w_hCls    = r_meta[r_rdPtr][7:6];
   assign w_hDst    = r_meta[r_rdPtr][5:1];
   assign w_nCls    = r_meta[w_rdPtr1][7:6];
   assign w_nDst    = r_meta[w_rdPtr1][5:1];
   assign w_nUsesRt = r_meta[w_rdPtr1][0];
   assign w_nRs     = r_instr[w_rdPtr1][25:21];
   assign w_nRt     = r_instr[w_rdPtr1][20:16];

   assign w_raw = (w_hDst != 5'd0) &&
                  ((w_nRs == w_hDst) || (w_nUsesRt && (w_nRt == w_hDst)));
   assign w_waw = (w_hDst != 5'd0) && (w_nDst == w_hDst);

   assign iss0_valid = (r_count != '0) && (r_state == RUN);
   assign iss1_valid = iss0_valid && (r_count >= CW'(2)) &&
                       (w_hCls != c_CLS_CTRL) &&
                       ((w_nCls == c_CLS_ALU) || (w_nCls == c_CLS_NOP)) &&
                       !w_raw && !w_waw;

   assign iss0_instr = r_instr[r_rdPtr];
   assign iss0_pc    = r_pc[r_rdPtr];
   assign iss1_instr = r_instr[w_rdPtr1];
   assign iss1_pc    = r_pc[w_rdPtr1];

   // Slot 1 never carries CTRL, so only the head can open a shadow window.
   assign w_ctrlPop = !issue_stall && iss0_valid && (w_hCls == c_CLS_CTRL);

   always_comb begin
      w_pushCnt = '0;
      if (in_ready && in_valid[0])
         w_pushCnt = in_valid[1] ? CW'(2) : CW'(1);
   end

   always_comb begin
      w_popCnt = '0;
      if (!issue_stall)
         w_popCnt = CW'(iss0_valid) + CW'(iss1_valid);
   end

   always_ff @(posedge clock) begin
      if (w_push0) begin
         r_instr[r_wrPtr] <= in_instr0;
         r_pc[r_wrPtr]    <= in_pc0;
         r_meta[r_wrPtr]  <= in_meta0;
      end
      if (w_push1) begin
         r_instr[w_wrPtr1] <= in_instr1;
         r_pc[w_wrPtr1]    <= in_pc1;
         r_meta[w_wrPtr1]  <= in_meta1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rdPtr     <= '0;
         r_wrPtr     <= '0;
         r_count     <= '0;
         r_state     <= RUN;
         r_shadowCnt <= '0;
      end else if (flush) begin
         r_rdPtr     <= '0;
         r_wrPtr     <= '0;
         r_count     <= '0;
         r_state     <= RUN;
         r_shadowCnt <= '0;
      end else begin
         r_wrPtr <= r_wrPtr + AW'(w_pushCnt);
         r_rdPtr <= r_rdPtr + AW'(w_popCnt);
         r_count <= r_count + w_pushCnt - w_popCnt;
         case (r_state)
            RUN: begin
               if (w_ctrlPop && (SHADOW_CYC > 0)) begin
                  r_state     <= SHADOW;
                  r_shadowCnt <= SW'(SHADOW_CYC);
               end
            end
            SHADOW: begin
               if (r_shadowCnt <= SW'(1)) begin
                  r_state     <= RUN;
                  r_shadowCnt <= '0;
               end else begin
                  r_shadowCnt <= r_shadowCnt - SW'(1);
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

`ifdef SCHED_STATS_EN
   logic [15:0] r_dualCnt, r_singleCnt;
   logic        w_issued2, w_issued1;

   assign w_issued2 = !issue_stall && iss1_valid;
   assign w_issued1 = !issue_stall && iss0_valid && !iss1_valid;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_dualCnt   <= '0;
         r_singleCnt <= '0;
      end else if (flush) begin
         r_dualCnt   <= '0;
         r_singleCnt <= '0;
      end else begin
         if (w_issued2 && (r_dualCnt != 16'hFFFF))
            r_dualCnt <= r_dualCnt + 16'd1;
         if (w_issued1 && (r_singleCnt != 16'hFFFF))
            r_singleCnt <= r_singleCnt + 16'd1;
      end
   end

   assign dual_cnt   = r_dualCnt;
   assign single_cnt = r_singleCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_issue_scheduler
// Purpose  : Directed self-checking bench for dual_issue_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_issue_scheduler;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   localparam logic [1:0] c_ALU  = 2'b00;
   localparam logic [1:0] c_MEM  = 2'b01;
   localparam logic [1:0] c_CTRL = 2'b10;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [1:0]    in_valid = '0;
   logic [31:0]   in_instr0 = '0, in_instr1 = '0;
   logic [5:0]    in_pc0 = '0, in_pc1 = '0;
   logic [7:0]    in_meta0 = '0, in_meta1 = '0;
   logic          in_ready;
   logic          issue_stall = 1'b0;
   logic          flush = 1'b0;
   logic          iss0_valid, iss1_valid;
   logic [31:0]   iss0_instr, iss1_instr;
   logic [5:0]    iss0_pc, iss1_pc;
   logic [CW-1:0] count;
`ifdef SCHED_STATS_EN
   logic [15:0]   dual_cnt, single_cnt;
`endif

   int nCompared   = 0;
   int nMismatched = 0;

   always #5 clock = ~clock;

   dual_issue_scheduler #(.DEPTH(DEPTH), .SHADOW_CYC(1)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_instr0   (in_instr0),
      .in_instr1   (in_instr1),
      .in_pc0      (in_pc0),
      .in_pc1      (in_pc1),
      .in_meta0    (in_meta0),
      .in_meta1    (in_meta1),
      .in_ready    (in_ready),
      .issue_stall (issue_stall),
      .flush       (flush),
      .iss0_valid  (iss0_valid),
      .iss0_instr  (iss0_instr),
      .iss0_pc     (iss0_pc),
      .iss1_valid  (iss1_valid),
      .iss1_instr  (iss1_instr),
      .iss1_pc     (iss1_pc),
      .count       (count)
`ifdef SCHED_STATS_EN
      ,.dual_cnt   (dual_cnt)
      ,.single_cnt (single_cnt)
`endif
   );

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
      return {6'd0, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt);
      return {op, rs, rt, 16'd0};
   endfunction

   function automatic logic [7:0] meta(input logic [1:0] cls, input logic [4:0] dst,
                                       input logic usesRt);
      return {cls, dst, usesRt};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pushTick(input logic [1:0] v,
                           input logic [31:0] i0, input logic [7:0] m0, input logic [5:0] p0,
                           input logic [31:0] i1, input logic [7:0] m1, input logic [5:0] p1);
      in_valid  = v;
      in_instr0 = i0; in_meta0 = m0; in_pc0 = p0;
      in_instr1 = i1; in_meta1 = m1; in_pc1 = p1;
      tick();
      in_valid = 2'b00;
      #1;
   endtask

   // Independent ALU op writing rd, reading r0 only.
   function automatic logic [31:0] aluI(input logic [4:0] rd);
      return rtype(5'd0, 5'd0, rd, 6'h20);
   endfunction

   logic [31:0] addA, addB, subR, lwI, add789, swI, beqI, aluA, aluB;

   initial begin
      addA   = rtype(5'd1, 5'd2, 5'd3, 6'h20);
      addB   = rtype(5'd5, 5'd6, 5'd4, 6'h20);
      subR   = rtype(5'd3, 5'd4, 5'd5, 6'h22);
      lwI    = itype(6'h23, 5'd1, 5'd2);
      add789 = rtype(5'd8, 5'd9, 5'd7, 6'h20);
      swI    = itype(6'h2B, 5'd5, 5'd4);
      beqI   = itype(6'h04, 5'd1, 5'd2);
      aluA   = rtype(5'd11, 5'd12, 5'd10, 6'h20);
      aluB   = rtype(5'd14, 5'd15, 5'd13, 6'h20);

      #2;
      check("rst_count", 32'(count), 0);
      check("rst_v0", 32'(iss0_valid), 0);
      check("rst_v1", 32'(iss1_valid), 0);
      check("rst_ready", 32'(in_ready), 1);
      tick(); tick();
      reset = 1'b1;
      #1;

      // Independent ALU pair dual-issues
      pushTick(2'b11, addA, meta(c_ALU, 5'd3, 1'b1), 6'd0, addB, meta(c_ALU, 5'd4, 1'b1), 6'd1);
      check("alu_count", 32'(count), 2);
      check("alu_v0", 32'(iss0_valid), 1);
      check("alu_v1", 32'(iss1_valid), 1);
      check("alu_pc0", 32'(iss0_pc), 0);
      check("alu_pc1", 32'(iss1_pc), 1);
      check("alu_instr1", iss1_instr, addB);
      tick();
      check("alu_drain_count", 32'(count), 0);
      check("alu_drain_v0", 32'(iss0_valid), 0);

      // RAW on r3 forces single issue
      pushTick(2'b11, addA, meta(c_ALU, 5'd3, 1'b1), 6'd2, subR, meta(c_ALU, 5'd5, 1'b1), 6'd3);
      check("raw_v0", 32'(iss0_valid), 1);
      check("raw_v1", 32'(iss1_valid), 0);
      tick();
      check("raw_next_count", 32'(count), 1);
      check("raw_next_instr", iss0_instr, subR);
      check("raw_next_v1", 32'(iss1_valid), 0);
      tick();
      check("raw_drain_count", 32'(count), 0);

      // MEM in slot 0 pairs; MEM in slot 1 does not
      pushTick(2'b11, lwI, meta(c_MEM, 5'd2, 1'b0), 6'd4, add789, meta(c_ALU, 5'd7, 1'b1), 6'd5);
      check("lw_v1", 32'(iss1_valid), 1);
      tick();
      check("lw_drain_count", 32'(count), 0);
      pushTick(2'b11, addA, meta(c_ALU, 5'd3, 1'b1), 6'd6, swI, meta(c_MEM, 5'd0, 1'b1), 6'd7);
      check("sw_v1", 32'(iss1_valid), 0);
      tick();
      check("sw_alone_instr", iss0_instr, swI);
      check("sw_alone_v0", 32'(iss0_valid), 1);
      check("sw_alone_v1", 32'(iss1_valid), 0);
      tick();

      // Branch issues alone, one shadow cycle, then the ALU pair
      pushTick(2'b11, beqI, meta(c_CTRL, 5'd0, 1'b1), 6'd10, aluA, meta(c_ALU, 5'd10, 1'b1), 6'd11);
      check("br_v0", 32'(iss0_valid), 1);
      check("br_v1", 32'(iss1_valid), 0);
      check("br_instr0", iss0_instr, beqI);
      pushTick(2'b01, aluB, meta(c_ALU, 5'd13, 1'b1), 6'd12, 32'd0, 8'd0, 6'd0);
      check("br_shadow_v0", 32'(iss0_valid), 0);
      check("br_shadow_v1", 32'(iss1_valid), 0);
      check("br_shadow_count", 32'(count), 2);
      tick();
      check("br_pair_v0", 32'(iss0_valid), 1);
      check("br_pair_v1", 32'(iss1_valid), 1);
      check("br_pair_pc0", 32'(iss0_pc), 11);
      check("br_pair_pc1", 32'(iss1_pc), 12);
      tick();
      check("br_drain_count", 32'(count), 0);

      // Flush inside the shadow window
      pushTick(2'b11, beqI, meta(c_CTRL, 5'd0, 1'b1), 6'd20, aluA, meta(c_ALU, 5'd10, 1'b1), 6'd21);
      tick();
      check("fsh_v0", 32'(iss0_valid), 0);
      check("fsh_count", 32'(count), 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fsh_flush_count", 32'(count), 0);
      check("fsh_flush_v0", 32'(iss0_valid), 0);
      pushTick(2'b11, aluI(5'd8), meta(c_ALU, 5'd8, 1'b1), 6'd30,
               aluI(5'd9), meta(c_ALU, 5'd9, 1'b1), 6'd31);
      check("fsh_run_v0", 32'(iss0_valid), 1);
      check("fsh_run_v1", 32'(iss1_valid), 1);
      tick();

      // Fill under stall; write pointer wraps from entry 2
      issue_stall = 1'b1;
      pushTick(2'b11, aluI(5'd16), meta(c_ALU, 5'd16, 1'b1), 6'd40,
               aluI(5'd17), meta(c_ALU, 5'd17, 1'b1), 6'd41);
      check("stall_v0", 32'(iss0_valid), 1);
      check("stall_count", 32'(count), 2);
      pushTick(2'b11, aluI(5'd18), meta(c_ALU, 5'd18, 1'b1), 6'd42,
               aluI(5'd19), meta(c_ALU, 5'd19, 1'b1), 6'd43);
      check("full_count", 32'(count), 4);
      check("full_ready", 32'(in_ready), 0);
      check("full_pc0", 32'(iss0_pc), 40);
      pushTick(2'b11, aluI(5'd20), meta(c_ALU, 5'd20, 1'b1), 6'd50,
               aluI(5'd21), meta(c_ALU, 5'd21, 1'b1), 6'd51);
      check("ign_count", 32'(count), 4);
      check("ign_pc0", 32'(iss0_pc), 40);
      check("ign_pc1", 32'(iss1_pc), 41);
      issue_stall = 1'b0;
      tick();
      check("wrap_count", 32'(count), 2);
      check("wrap_ready", 32'(in_ready), 1);
      check("wrap_pc0", 32'(iss0_pc), 42);
      check("wrap_pc1", 32'(iss1_pc), 43);
      tick();
      check("wrap_drain_count", 32'(count), 0);
      pushTick(2'b11, aluI(5'd20), meta(c_ALU, 5'd20, 1'b1), 6'd44,
               aluI(5'd21), meta(c_ALU, 5'd21, 1'b1), 6'd45);
      check("wrap2_pc0", 32'(iss0_pc), 44);
      check("wrap2_pc1", 32'(iss1_pc), 45);
      tick();

      // Flush wins over a same-edge push
      issue_stall = 1'b1;
      pushTick(2'b11, aluI(5'd22), meta(c_ALU, 5'd22, 1'b1), 6'd60,
               aluI(5'd23), meta(c_ALU, 5'd23, 1'b1), 6'd61);
      flush = 1'b1;
      pushTick(2'b11, aluI(5'd24), meta(c_ALU, 5'd24, 1'b1), 6'd62,
               aluI(5'd25), meta(c_ALU, 5'd25, 1'b1), 6'd63);
      flush = 1'b0;
      check("fpush_count", 32'(count), 0);
      check("fpush_v0", 32'(iss0_valid), 0);
      check("fpush_v1", 32'(iss1_valid), 0);

      // Asynchronous reset mid-stream
      pushTick(2'b11, aluI(5'd22), meta(c_ALU, 5'd22, 1'b1), 6'd60,
               aluI(5'd23), meta(c_ALU, 5'd23, 1'b1), 6'd61);
      check("mid_count", 32'(count), 2);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_v0", 32'(iss0_valid), 0);
      check("mid_rst_v1", 32'(iss1_valid), 0);
      check("mid_rst_count", 32'(count), 0);
      check("mid_rst_ready", 32'(in_ready), 1);
      tick();
      reset = 1'b1;
      issue_stall = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
`default_nettype wire
